// File: rtl/data_mem_resp.sv
// Single-port data memory with fixed-latency, in-order responses to an LSU.
// Optional address range check is enabled with the DMEM_ADDR_CHECK_EN macro.
module data_mem_resp #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_gnt,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_error
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = 3;

    logic [31:0]         mem [MEM_WORDS];
    logic [AW-1:0]       idx;
    logic                accept;
    logic                addr_err;
    logic [CW-1:0]       count;
    logic [LATENCY-1:0]  pipe_valid;
    logic [LATENCY-1:0]  pipe_error;
    logic [31:0]         pipe_rdata [LATENCY];
    logic                unused_addr_bits;

    assign idx              = data_addr[AW+1:2];
    assign unused_addr_bits = ^{data_addr[1:0], data_addr[31:AW+2]};

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = |data_addr[31:AW+2];
`else
    assign addr_err = 1'b0;
`endif

    // Grant never looks at address/write/byte-enable, only request and state.
    assign data_gnt = data_req && !reset && (count < CW'(MAX_OUTSTANDING));
    assign accept   = data_gnt;

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && data_wr && !addr_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_be[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Non-valid stages carry zero data so the outputs are clean without gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_error <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_rdata[i] <= '0;
            end
            count <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_error[0] <= accept && addr_err;
            pipe_rdata[0] <= (accept && !data_wr && !addr_err) ? mem[idx] : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_error[i] <= pipe_error[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
            case ({accept, data_valid})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign data_valid = pipe_valid[LATENCY-1];
    assign data_error = pipe_error[LATENCY-1];
    assign data_rdata = pipe_rdata[LATENCY-1];

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three instances cover LATENCY 1, 4 and 3.
// Expectations for the out-of-range case follow DMEM_ADDR_CHECK_EN.
module tb_data_mem_resp;

`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst0, req0, wr0, gnt0, valid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;

    logic        rst1, req1, gnt1, valid1, err1;
    logic [31:0] rdata1;

    logic        rst2, req2, gnt2, valid2, err2;
    logic [31:0] rdata2;

    logic        zero_wr  = 1'b0;
    logic [31:0] zero_w32 = '0;
    logic [3:0]  full_be  = 4'hF;

    data_mem_resp #(.MEM_WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
        .clk(clk), .reset(rst0), .data_req(req0), .data_wr(wr0), .data_addr(addr0),
        .data_wdata(wdata0), .data_be(be0), .data_gnt(gnt0), .data_valid(valid0),
        .data_rdata(rdata0), .data_error(err0));

    data_mem_resp #(.MEM_WORDS(1024), .LATENCY(4), .MAX_OUTSTANDING(2)) u1 (
        .clk(clk), .reset(rst1), .data_req(req1), .data_wr(zero_wr), .data_addr(zero_w32),
        .data_wdata(zero_w32), .data_be(full_be), .data_gnt(gnt1), .data_valid(valid1),
        .data_rdata(rdata1), .data_error(err1));

    data_mem_resp #(.MEM_WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(2)) u2 (
        .clk(clk), .reset(rst2), .data_req(req2), .data_wr(zero_wr), .data_addr(zero_w32),
        .data_wdata(zero_w32), .data_be(full_be), .data_gnt(gnt2), .data_valid(valid2),
        .data_rdata(rdata2), .data_error(err2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        req0 = r; wr0 = w; addr0 = a; wdata0 = d; be0 = b;
        #1;
    endtask

    task automatic resp0(input string tag, input logic v, input logic [31:0] d, input logic e);
        check({tag, "_valid"}, {31'd0, valid0}, {31'd0, v});
        check({tag, "_rdata"}, rdata0, d);
        check({tag, "_error"}, {31'd0, err0}, {31'd0, e});
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        req1 = 1'b0; req2 = 1'b0;
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        tick();
        resp0("rst", 1'b0, 32'h0, 1'b0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        tick();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Basic store then load, LATENCY 1
        drive0(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF);
        check("st10_gnt", {31'd0, gnt0}, 32'd1);
        tick();
        resp0("st10", 1'b1, 32'h0, 1'b0);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        check("ld10_gnt", {31'd0, gnt0}, 32'd1);
        tick();
        resp0("ld10", 1'b1, 32'h12345678, 1'b0);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("idle_gnt", {31'd0, gnt0}, 32'd0);
        tick();
        resp0("idle1", 1'b0, 32'h0, 1'b0);

        // Byte-enable merge
        drive0(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF); tick();
        drive0(1'b1, 1'b1, 32'h20, 32'h00000011, 4'h1); tick();
        resp0("st20b", 1'b1, 32'h0, 1'b0);
        drive0(1'b1, 1'b0, 32'h20, 32'h0, 4'hF); tick();
        resp0("ld20", 1'b1, 32'hAABBCC11, 1'b0);

        // be=0000 store writes nothing; load with be=0000 returns full word
        drive0(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0); tick();
        resp0("stbe0", 1'b1, 32'h0, 1'b0);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); tick();
        resp0("ldbe0", 1'b1, 32'h12345678, 1'b0);

        // Back-to-back in-order loads
        drive0(1'b1, 1'b1, 32'h0, 32'h0A0A0A0A, 4'hF); tick();
        drive0(1'b1, 1'b1, 32'h4, 32'h0B0B0B0B, 4'hF); tick();
        drive0(1'b1, 1'b1, 32'h8, 32'h0C0C0C0C, 4'hF); tick();
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 4'hF); tick();
        resp0("b2b0", 1'b1, 32'h0A0A0A0A, 1'b0);
        drive0(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        check("b2b_gnt", {31'd0, gnt0}, 32'd1);
        tick();
        resp0("b2b1", 1'b1, 32'h0B0B0B0B, 1'b0);
        drive0(1'b1, 1'b0, 32'h8, 32'h0, 4'hF); tick();
        resp0("b2b2", 1'b1, 32'h0C0C0C0C, 1'b0);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick();
        resp0("idle2", 1'b0, 32'h0, 1'b0);

        // Out-of-range address: error + suppressed store, or wrap to word 0
        drive0(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF); tick();
        resp0("oob_st", 1'b1, 32'h0, CHK);
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 4'hF); tick();
        resp0("oob_w0", 1'b1, CHK ? 32'h0A0A0A0A : 32'hDEADBEEF, 1'b0);
        drive0(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF); tick();
        resp0("oob_ld", 1'b1, CHK ? 32'h0 : 32'hDEADBEEF, CHK);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick();
        resp0("idle3", 1'b0, 32'h0, 1'b0);

        // LATENCY 4, MAX_OUTSTANDING 2: two grants then stall until first response
        req1 = 1'b1; #1;
        check("l4_c0_gnt", {31'd0, gnt1}, 32'd1); tick();
        check("l4_c1_gnt", {31'd0, gnt1}, 32'd1);
        check("l4_c1_val", {31'd0, valid1}, 32'd0); tick();
        check("l4_c2_gnt", {31'd0, gnt1}, 32'd0);
        check("l4_c2_val", {31'd0, valid1}, 32'd0); tick();
        check("l4_c3_gnt", {31'd0, gnt1}, 32'd0);
        check("l4_c3_val", {31'd0, valid1}, 32'd0); tick();
        check("l4_c4_gnt", {31'd0, gnt1}, 32'd0);
        check("l4_c4_val", {31'd0, valid1}, 32'd1);
        check("l4_c4_err", {31'd0, err1}, 32'd0); tick();
        req1 = 1'b0; #1;
        check("l4_c5_val", {31'd0, valid1}, 32'd1); tick();
        check("l4_c6_val", {31'd0, valid1}, 32'd0);
        req1 = 1'b1; #1;
        check("l4_drain_gnt", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;

        // LATENCY 3: reset one cycle after a grant drops the in-flight response
        req2 = 1'b1; #1;
        check("l3_gnt", {31'd0, gnt2}, 32'd1); tick();
        rst2 = 1'b1; #1;
        check("l3_rst_gnt", {31'd0, gnt2}, 32'd0); tick();
        rst2 = 1'b0; req2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("l3_no_val", {31'd0, valid2}, 32'd0);
            tick();
        end
        req2 = 1'b1; #1;
        check("l3_post_gnt0", {31'd0, gnt2}, 32'd1); tick();
        check("l3_post_gnt1", {31'd0, gnt2}, 32'd1); tick();
        check("l3_post_gnt2", {31'd0, gnt2}, 32'd0);
        req2 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
